centroid_readout: RTL
=====================

Name: centroid_readout

Overview:
- Sits directly downstream of the connected-components labeler.
- On a frame-end pulse, it latches the labeler's label count and walks the object table by driving the labeler's `obj_id` request port.
- It captures the returned `obj_x`/`obj_y` centroid pair for each label.
- It streams {id, x, y} records out through a small FIFO with a valid/ready handshake, for the host/overlay stage.

Parameters:
- WORD_SIZE, 8, width of labels and label count; matches the labeler's word size.
- READ_LATENCY, 1, cycles from `obj_id` change to valid `obj_x`/`obj_y`; 0 means combinational (same cycle).
- FIFO_DEPTH, 4, output record buffer depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_done  in  1  one-cycle pulse: labeling of the current frame is complete.
- num_labels  in  WORD_SIZE  labeler's next-free label; valid labels are 1..num_labels-1.
- obj_x  in  16  centroid x for the requested obj_id.
- obj_y  in  16  centroid y for the requested obj_id.
- obj_id  out  WORD_SIZE  label requested from the labeler's object table.
- out_valid  out  1  the head record is valid.
- out_ready  in  1  the consumer accepts the head record.
- out_id  out  WORD_SIZE  label of the head record.
- out_x  out  16  centroid x of the head record.
- out_y  out  16  centroid y of the head record.
- busy  out  1  a readout is in progress.
- done  out  1  one-cycle pulse: readout finished.
- overrun  out  1  one-cycle pulse: frame_done arrived while busy.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; obj_id = 0; FIFO empty (out_valid = 0).
  - out_id/out_x/out_y = 0; busy = 0; done = 0; overrun = 0.
  - In-flight read pipeline cleared.
  - Reset mid-readout discards all pending and buffered records.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On frame_done, latch n = num_labels.
  - If n <= 1: pulse done the next cycle and stay IDLE; no records emitted.
  - Otherwise: obj_id <= 1, busy <= 1, go to ISSUE.
- ISSUE:
  - Each cycle, a read of the current obj_id is issued if (fifo_count + inflight) < FIFO_DEPTH (credit rule). A stalled cycle holds obj_id unchanged.
  - After an issue, obj_id increments.
  - When the issued id equals n-1, go to DRAIN; obj_id holds n-1.
- Read pipeline:
  - The id issued at cycle t is paired with obj_x/obj_y sampled at cycle t+READ_LATENCY, then pushed into the FIFO.
  - A READ_LATENCY-deep shift register carries the {valid, id}.
  - With READ_LATENCY=0, the push happens at cycle t.
- FIFO:
  - out_valid = not empty; out_id/out_x/out_y reflect the head (first-word-fall-through).
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - The credit rule guarantees no push while full; a push while full is a design error (assertion in bench).
  - Records emerge in strictly ascending id order.
- DRAIN:
  - Wait until inflight = 0 and the FIFO is empty.
  - Then, the next cycle: done = 1 for one cycle, busy = 0, obj_id = 0, go to IDLE.
- frame_done while busy:
  - overrun pulses for one cycle (next cycle).
  - The request is ignored; the current readout is unaffected.
- frame_done in the same cycle as the done pulse is treated as a new IDLE request and accepted.
- Width rules:
  - obj_id counts within WORD_SIZE; maximum n = 2^WORD_SIZE-1, so the last id is 2^WORD_SIZE-2 and the counter never wraps.
  - Centroids pass through unmodified; no arithmetic is performed on x/y.
- out_ready may toggle arbitrarily. While out_valid=1 and out_ready=0, head outputs are held stable.

Test Plan:
- Model returns x=10*id, y=20*id after READ_LATENCY=1; num_labels=4; out_ready=1; frame_done pulse -> records (1,10,20), (2,20,40), (3,30,60) in order, then one done pulse; busy low afterwards.
- num_labels=1; frame_done -> out_valid never asserts; done pulses exactly once, the cycle after frame_done.
- num_labels=10; FIFO_DEPTH=4; out_ready=0 -> exactly 4 records buffered (ids 1..4); obj_id stalls; no loss. Random out_ready afterwards -> ids 1..9 complete and in order, with stable heads during stalls.
- frame_done re-pulsed mid-readout (num_labels=6) -> overrun pulses once; output stream is still ids 1..5 and a single done.
- Reset asserted with 3 records buffered -> next cycle: out_valid=0, busy=0, obj_id=0. A new frame_done with num_labels=3 -> ids 1, 2 only.
- num_labels=255, READ_LATENCY=0 and 2 variants -> ids 1..254 emitted; no wrap to 0; done once.

Source files
------------

// File: rtl/centroid_readout.sv
// Walks the labeler's object table after each frame and streams {id, x, y}
// centroid records through a small first-word-fall-through FIFO.
module centroid_readout #(
    parameter int WORD_SIZE    = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_done,
    input  logic [WORD_SIZE-1:0] num_labels,
    input  logic [15:0]          obj_x,
    input  logic [15:0]          obj_y,
    output logic [WORD_SIZE-1:0] obj_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_id,
    output logic [15:0]          out_x,
    output logic [15:0]          out_y,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int RW = WORD_SIZE + 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic [WORD_SIZE-1:0] r_n, w_n_nx;
    logic [WORD_SIZE-1:0] r_obj_id, w_obj_id_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;
    logic                 r_overrun, w_overrun_nx;
    logic                 w_issue, w_push, w_pop;
    logic [WORD_SIZE-1:0] w_push_id;
    logic [CW-1:0]        w_inflight;
    logic [RW-1:0]        r_mem [FIFO_DEPTH];
    logic [RW-1:0]        w_head;
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;

    // Credit rule: never issue a read that could not land in the FIFO.
    assign w_issue = (r_state == S_ISSUE) && ((r_count + w_inflight) < CW'(FIFO_DEPTH));

    generate
        if (READ_LATENCY == 0) begin : g_comb
            assign w_push     = w_issue;
            assign w_push_id  = r_obj_id;
            assign w_inflight = '0;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] r_pv;
            logic [WORD_SIZE-1:0]    r_pid [READ_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pv <= '0;
                    for (int i = 0; i < READ_LATENCY; i++) r_pid[i] <= '0;
                end else begin
                    r_pv[0]  <= w_issue;
                    r_pid[0] <= r_obj_id;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        r_pv[i]  <= r_pv[i-1];
                        r_pid[i] <= r_pid[i-1];
                    end
                end
            end

            assign w_push    = r_pv[READ_LATENCY-1];
            assign w_push_id = r_pid[READ_LATENCY-1];

            always_comb begin
                w_inflight = '0;
                for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + CW'(r_pv[i]);
            end
        end
    endgenerate

    always_comb begin
        w_state_nx   = r_state;
        w_n_nx       = r_n;
        w_obj_id_nx  = r_obj_id;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_overrun_nx = frame_done && r_busy;
        case (r_state)
            S_IDLE: begin
                if (frame_done) begin
                    w_n_nx = num_labels;
                    if (num_labels <= WORD_SIZE'(1)) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_obj_id_nx = WORD_SIZE'(1);
                        w_busy_nx   = 1'b1;
                        w_state_nx  = S_ISSUE;
                    end
                end else begin
                    w_n_nx = r_n;
                end
            end
            S_ISSUE: begin
                if (w_issue && (r_obj_id == (r_n - WORD_SIZE'(1)))) begin
                    w_state_nx = S_DRAIN;
                end else if (w_issue) begin
                    w_obj_id_nx = r_obj_id + WORD_SIZE'(1);
                end else begin
                    w_obj_id_nx = r_obj_id;
                end
            end
            S_DRAIN: begin
                if ((w_inflight == '0) && (r_count == '0)) begin
                    w_done_nx   = 1'b1;
                    w_busy_nx   = 1'b0;
                    w_obj_id_nx = '0;
                    w_state_nx  = S_IDLE;
                end else begin
                    w_state_nx = S_DRAIN;
                end
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_busy_nx   = 1'b0;
                w_obj_id_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_obj_id  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_n       <= w_n_nx;
            r_obj_id  <= w_obj_id_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_overrun <= w_overrun_nx;
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_push_id, obj_x, obj_y};
    end

    assign w_pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_valid = (r_count != '0);
    assign out_id    = out_valid ? w_head[RW-1:32] : '0;
    assign out_x     = out_valid ? w_head[31:16]   : 16'd0;
    assign out_y     = out_valid ? w_head[15:0]    : 16'd0;
    assign obj_id    = r_obj_id;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule
